// File: rtl/util_sgmii_pkg.sv
// Shared types and constants for the SGMII link monitor: FSM state encoding,
// PCS status_vector bit positions and speed codes.
package util_sgmii_pkg;

  typedef enum logic [2:0] {
    ST_DOWN,
    ST_QUALIFY,
    ST_UP,
    ST_RECOVER,
    ST_HOLDOFF
  } link_mon_state_t;

  localparam int STS_LINK      = 0;
  localparam int STS_SYNC      = 1;
  localparam int STS_SPEED_LSB = 10;
  localparam int STS_DUPLEX    = 12;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/util_sync_ff.sv
// Two-flop synchroniser for quasi-static status bits crossing into clk.
// Both stages reset to zero.
module util_sync_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/util_sgmii_link_monitor.sv
// SGMII PCS/PMA link supervisor: debounced link_up, speed/duplex latch, PCS
// reset on sync timeout, event counters. Optional irq via UTIL_SGMII_LINK_MONITOR_IRQ_EN.
module util_sgmii_link_monitor
  import util_sgmii_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int SYNC_TIMEOUT    = 12500000,
  parameter int RESET_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES  = 1250000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   link_status,
  input  logic                   link_sync,
  input  logic [1:0]             speed,
  input  logic                   duplex,
  input  logic                   clr_counters,
  output logic                   link_up,
  output logic [1:0]             link_speed,
  output logic                   link_duplex,
  output logic                   pcs_reset,
  output logic [COUNT_WIDTH-1:0] link_down_count,
  output logic [COUNT_WIDTH-1:0] retrain_count
`ifdef UTIL_SGMII_LINK_MONITOR_IRQ_EN
  ,
  output logic                   irq,
  input  logic                   irq_ack
`endif
);

  localparam int TIMER_MAX = max_of(max_of(DEBOUNCE_CYCLES, SYNC_TIMEOUT),
                                    max_of(RESET_CYCLES, HOLDOFF_CYCLES));
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef logic [TIMER_W-1:0] timer_t;

  localparam timer_t DEB_LAST  = timer_t'(DEBOUNCE_CYCLES - 1);
  localparam timer_t TO_LAST   = timer_t'(SYNC_TIMEOUT - 1);
  localparam timer_t RST_LAST  = timer_t'(RESET_CYCLES - 1);
  localparam timer_t HOLD_LAST = timer_t'(HOLDOFF_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  link_mon_state_t state, next_state;
  timer_t          timer, timer_next;
  logic            status_s, sync_s, link_ok;
  logic            qual_done, drop_evt, retrain_evt;

  util_sync_ff #(.WIDTH(1)) u_sync_status (
    .clk (clk),
    .rst (rst),
    .d   (link_status),
    .q   (status_s)
  );

  util_sync_ff #(.WIDTH(1)) u_sync_sync (
    .clk (clk),
    .rst (rst),
    .d   (link_sync),
    .q   (sync_s)
  );

  assign link_ok = status_s & sync_s;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    timer_next  = timer + 1'b1;
    qual_done   = 1'b0;
    drop_evt    = 1'b0;
    retrain_evt = 1'b0;
    unique case (state)
      ST_DOWN: begin
        if (link_ok) begin
          next_state = ST_QUALIFY;
          timer_next = '0;
        end else if (timer == TO_LAST) begin
          next_state  = ST_RECOVER;
          timer_next  = '0;
          retrain_evt = 1'b1;
        end
      end
      ST_QUALIFY: begin
        // A drop on the final debounce cycle still aborts qualification.
        if (!link_ok) begin
          next_state = ST_DOWN;
          timer_next = '0;
        end else if (timer == DEB_LAST) begin
          next_state = ST_UP;
          timer_next = '0;
          qual_done  = 1'b1;
        end
      end
      ST_UP: begin
        timer_next = '0;
        if (!link_ok) begin
          next_state = ST_DOWN;
          drop_evt   = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (timer == RST_LAST) begin
          next_state = ST_HOLDOFF;
          timer_next = '0;
        end
      end
      ST_HOLDOFF: begin
        if (timer == HOLD_LAST) begin
          next_state = ST_DOWN;
          timer_next = '0;
        end
      end
      default: begin
        next_state = ST_DOWN;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_DOWN;
      timer       <= '0;
      link_up     <= 1'b0;
      link_speed  <= SPEED_10M;
      link_duplex <= 1'b0;
      pcs_reset   <= 1'b0;
    end else begin
      state     <= next_state;
      timer     <= timer_next;
      link_up   <= (next_state == ST_UP);
      // Retimed off the state register: glitch-free, trails RECOVER by a cycle.
      pcs_reset <= (state == ST_RECOVER);
      if (qual_done) begin
        link_speed  <= speed;
        link_duplex <= duplex;
      end
    end
  end

  // Clear has priority over a coincident increment; counts saturate.
  always_ff @(posedge clk) begin
    if (rst || clr_counters) begin
      link_down_count <= '0;
      retrain_count   <= '0;
    end else begin
      if (drop_evt && (link_down_count != CNT_MAX))
        link_down_count <= link_down_count + 1'b1;
      if (retrain_evt && (retrain_count != CNT_MAX))
        retrain_count <= retrain_count + 1'b1;
    end
  end

`ifdef UTIL_SGMII_LINK_MONITOR_IRQ_EN
  logic irq_set;

  assign irq_set = ((next_state == ST_UP) != link_up) || retrain_evt;

  always_ff @(posedge clk) begin
    if (rst)          irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end
`endif

endmodule
